// File: rtl/loop_seq_pkg.sv
// Shared types and default widths for the loop sequencer.
// Frame layout and FSM states used by the top and the PC stack.
package loop_seq_pkg;

  localparam int PC_W     = 10;
  localparam int CNT_W    = 15;
  localparam int BODY_W   = 8;
  localparam int LOG_CNT  = 3;
  localparam int LOOP_CNT = 1 << LOG_CNT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_UNWIND,
    S_HALT,
    S_ERR
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] start_pc;
    logic [PC_W-1:0] end_pc;
  } loop_frame_t;

endpackage

// File: rtl/loop_pc_stack.sv
// LIFO of loop frames; exposes the top entry and the one beneath it.
// Storage is unreset; only the depth counter is cleared.
module loop_pc_stack
  import loop_seq_pkg::*;
#(
  parameter int W   = 2 * PC_W,
  parameter int LOG = LOG_CNT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic [W-1:0] below_o,
  output logic [LOG:0] depth_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << LOG;

  logic [W-1:0]   mem_q [DEPTH];
  logic [LOG:0]   depth_q;
  logic [LOG:0]   depth_d;
  logic [LOG-1:0] wr_idx;
  logic [LOG-1:0] top_idx;
  logic [LOG-1:0] below_idx;

  assign wr_idx    = depth_q[LOG-1:0];
  assign top_idx   = wr_idx - LOG'(1);
  assign below_idx = wr_idx - LOG'(2);
  assign full_o    = depth_q == (LOG+1)'(DEPTH);
  assign empty_o   = depth_q == '0;
  assign depth_o   = depth_q;
  assign top_o     = mem_q[top_idx];
  assign below_o   = mem_q[below_idx];

  always_comb begin
    depth_d = depth_q;
    if (clear_i)
      depth_d = '0;
    else if (push_i && !full_o)
      depth_d = depth_q + (LOG+1)'(1);
    else if (pop_i && !empty_o)
      depth_d = depth_q - (LOG+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      depth_q <= '0;
    else
      depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clear_i)
      mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/loop_sequencer.sv
// Loop-stack initiator: owns the PC, issues instructions and
// drives create/next/finish strobes to the loop unit.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int PC_BITS      = PC_W,
  parameter int BITS         = CNT_W,
  parameter int BODY_BITS    = BODY_W,
  parameter int LOOP_LOG_CNT = LOG_CNT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PC_BITS-1:0]   start_pc,
  output logic [PC_BITS-1:0]   fetch_pc,
  input  logic                 inst_valid,
  input  logic                 inst_is_loop,
  input  logic                 inst_is_halt,
  input  logic [BITS-1:0]      inst_loop_count,
  input  logic                 inst_loop_independent,
  input  logic [BODY_BITS-1:0] inst_body_len,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic                 should_increment,
  output logic                 should_create_new_loop,
  output logic [BITS-1:0]      new_loop_iteration_count,
  output logic                 new_loop_is_inner_independent_loop,
  output logic                 did_start_next_loop_iteration,
  output logic                 did_finish_loop,
  input  logic                 loop_done,
  output logic                 busy,
  output logic                 halted,
  output logic                 error
);

  localparam int PCW1 = PC_BITS + 1;

  typedef struct packed {
    logic [PC_BITS-1:0] start_pc;
    logic [PC_BITS-1:0] end_pc;
  } frame_t;

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] pc_inc;
  logic [PC_BITS:0]   end_wide;
  frame_t             top, below, push_frame;
  logic [LOOP_LOG_CNT:0] depth;
  logic fire, full, empty, at_end, chain, loop_bad;
  logic push, pop, clear;

  loop_pc_stack #(
    .W   (2 * PC_BITS),
    .LOG (LOOP_LOG_CNT)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_frame),
    .top_o   (top),
    .below_o (below),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );

  assign fire     = (state_q == S_RUN) & inst_valid & issue_ready;
  assign pc_inc   = pc_q + PC_BITS'(1);
  assign end_wide = PCW1'(pc_q) + PCW1'(inst_body_len);
  assign at_end   = !empty && (pc_q == top.end_pc);
  // Popping the top also closes the frame below when both end here.
  assign chain    = (depth[LOOP_LOG_CNT:1] != '0)
                 && (below.end_pc == top.end_pc);
  assign loop_bad = (inst_loop_count == '0)
                 || (inst_body_len == '0)
                 || full
                 || end_wide[PC_BITS]
                 || (!empty && end_wide[PC_BITS-1:0] > top.end_pc);

  assign push_frame.start_pc = pc_inc;
  assign push_frame.end_pc   = end_wide[PC_BITS-1:0];

  assign fetch_pc = pc_q;
  assign should_increment = fire | (state_q == S_UNWIND);
  assign new_loop_iteration_count = inst_loop_count;
  assign new_loop_is_inner_independent_loop = inst_loop_independent;
  assign busy   = (state_q == S_RUN) | (state_q == S_UNWIND);
  assign halted = (state_q == S_HALT) | (state_q == S_ERR);
  assign error  = state_q == S_ERR;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    issue_valid = 1'b0;
    should_create_new_loop = 1'b0;
    did_start_next_loop_iteration = 1'b0;
    did_finish_loop = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = start_pc;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (fire) begin
          if (inst_is_halt) begin
            state_d = empty ? S_HALT : S_ERR;
          end else if (inst_is_loop) begin
            issue_valid = 1'b1;
            if (loop_bad) begin
              state_d = S_ERR;
            end else begin
              push = 1'b1;
              should_create_new_loop = 1'b1;
              pc_d = pc_inc;
            end
          end else if (at_end) begin
            issue_valid = 1'b1;
            if (loop_done) begin
              did_finish_loop = 1'b1;
              pop = 1'b1;
              if (chain) state_d = S_UNWIND;
              else       pc_d = pc_inc;
            end else begin
              did_start_next_loop_iteration = 1'b1;
              pc_d = top.start_pc;
            end
          end else begin
            issue_valid = 1'b1;
            pc_d = pc_inc;
          end
        end
      end
      S_UNWIND: begin
        if (loop_done) begin
          did_finish_loop = 1'b1;
          pop = 1'b1;
          if (!chain) begin
            state_d = S_RUN;
            pc_d    = pc_inc;
          end
        end else begin
          did_start_next_loop_iteration = 1'b1;
          pc_d    = top.start_pc;
          state_d = S_RUN;
        end
      end
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule
